// File: rtl/stop_debouncer_if.sv
// CPU data-bus write port as seen by memory-mapped peripherals.
// The master drives the bus; the peripheral samples it through the slave modport.
interface stop_debouncer_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic                  dmem_wen;
    logic                  dmem_byt;
    logic [15:0]           dmem_wdata;

    modport master (
        output dmem_addr,
        output dmem_wen,
        output dmem_byt,
        output dmem_wdata
    );

    modport slave (
        input dmem_addr,
        input dmem_wen,
        input dmem_byt,
        input dmem_wdata
    );
endinterface

// File: rtl/stop_debouncer.sv
// Stop-switch debouncer: synchronises the raw active-low switch, accepts level
// changes only after DEBOUNCE_CYCLES stable samples, and keeps sticky event flags.
module stop_debouncer #(
    parameter int unsigned          DEBOUNCE_CYCLES = 270000,
    parameter int unsigned          ADDR_WIDTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] CLR_ADDR       = ADDR_WIDTH'('h084)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stop_n_raw,
    stop_debouncer_if.slave     dmem,
    output logic                stop_level,
    output logic                press_pulse,
    output logic [15:0]         status
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       sync_q;
    logic             press_flag;
    logic             release_flag;
    logic [7:0]       press_count;

    logic raw_pressed_c;
    logic press_accept_c;
    logic release_accept_c;
    logic clr_wr_c;
    logic unused_bus;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], stop_n_raw};
        end
    end

    assign raw_pressed_c    = ~sync_q[1];
    assign press_accept_c   = (state == PRESS_WAIT)   &&  raw_pressed_c && (cnt == CNT_LAST);
    assign release_accept_c = (state == RELEASE_WAIT) && !raw_pressed_c && (cnt == CNT_LAST);
    assign clr_wr_c         = dmem.dmem_wen && (dmem.dmem_addr == CLR_ADDR);

    // Byte flag and the middle write-data bits carry no meaning for this register.
    assign unused_bus = &{1'b0, dmem.dmem_byt, dmem.dmem_wdata[14:2]};

    // Debounce FSM with registered level and press strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            stop_level  <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (raw_pressed_c) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!raw_pressed_c) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRESSED;
                        stop_level  <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!raw_pressed_c) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (raw_pressed_c) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state      <= RELEASED;
                        stop_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= RELEASED;
                    cnt        <= '0;
                    stop_level <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags and press counter; a same-cycle set or increment beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_flag   <= 1'b0;
            release_flag <= 1'b0;
            press_count  <= 8'd0;
        end else begin
            if (press_accept_c) begin
                press_flag <= 1'b1;
            end else if (clr_wr_c && dmem.dmem_wdata[0]) begin
                press_flag <= 1'b0;
            end

            if (release_accept_c) begin
                release_flag <= 1'b1;
            end else if (clr_wr_c && dmem.dmem_wdata[1]) begin
                release_flag <= 1'b0;
            end

            if (press_accept_c) begin
                press_count <= (clr_wr_c && dmem.dmem_wdata[15]) ? 8'd1 : press_count + 8'd1;
            end else if (clr_wr_c && dmem.dmem_wdata[15]) begin
                press_count <= 8'd0;
            end
        end
    end

    assign status = {press_count, 5'd0, release_flag, press_flag, stop_level};

endmodule

// File: tb/tb_stop_debouncer.sv
// Scoreboard bench for stop_debouncer with DEBOUNCE_CYCLES=4: stimulus queues
// expected level/pulse events, a negedge monitor pops and checks them.
module tb_stop_debouncer;

    localparam int unsigned D = 4;
    localparam int LAT = D + 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop_n_raw;
    logic        stop_level;
    logic        press_pulse;
    logic [15:0] status;

    stop_debouncer_if #(.ADDR_WIDTH(16)) bus ();

    stop_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .ADDR_WIDTH     (16),
        .CLR_ADDR       (16'h0084)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stop_n_raw (stop_n_raw),
        .dmem       (bus),
        .stop_level (stop_level),
        .press_pulse(press_pulse),
        .status     (status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] st;
        logic        pulse;
        logic        lvl;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_e;
    int   errors = 0;
    int   checks = 0;
    logic prev_lvl = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Any pulse or level change is an event that must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_lvl = 1'b0;
        end else begin
            if (press_pulse || (stop_level != prev_lvl)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: edge %0d status=%h level=%b pulse=%b, expected no event",
                             cyc, status, stop_level, press_pulse);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_edge",   32'(cyc),         32'(mon_e.at));
                    check("event_status", 32'(status),      32'(mon_e.st));
                    check("event_pulse",  32'(press_pulse), 32'(mon_e.pulse));
                    check("event_level",  32'(stop_level),  32'(mon_e.lvl));
                end
            end
            prev_lvl = stop_level;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_cycle(input logic [15:0] addr, input logic [15:0] data, input logic wen);
        bus.dmem_addr  = addr;
        bus.dmem_wdata = data;
        bus.dmem_wen   = wen;
        tick(1);
        bus.dmem_wen   = 1'b0;
    endtask

    // Press and hold; optionally write the clear register in the acceptance cycle.
    task automatic press(input logic [15:0] st, input logic do_wr, input logic [15:0] wd);
        stop_n_raw = 1'b0;
        exp_q.push_back('{at: cyc + LAT, st: st, pulse: 1'b1, lvl: 1'b1});
        if (do_wr) begin
            tick(LAT - 1);
            bus_cycle(16'h0084, wd, 1'b1);
            tick(3);
        end else begin
            tick(LAT + 3);
        end
    endtask

    task automatic release_sw(input logic [15:0] st);
        stop_n_raw = 1'b1;
        exp_q.push_back('{at: cyc + LAT, st: st, pulse: 1'b0, lvl: 1'b0});
        tick(LAT + 3);
    endtask

    initial begin
        rst            = 1'b1;
        stop_n_raw     = 1'b1;
        bus.dmem_addr  = 16'h0000;
        bus.dmem_wen   = 1'b0;
        bus.dmem_byt   = 1'b0;
        bus.dmem_wdata = 16'h0000;
        tick(3);
        check("reset_status", 32'(status),      32'h0000);
        check("reset_level",  32'(stop_level),  32'h0);
        check("reset_pulse",  32'(press_pulse), 32'h0);
        rst = 1'b0;
        tick(2);

        // Short low glitches never reach the acceptance count.
        for (int i = 0; i < 10; i++) begin
            stop_n_raw = 1'b0;
            tick(2);
            stop_n_raw = 1'b1;
            tick(3);
        end
        tick(4);
        check("glitch_status", 32'(status), 32'h0000);

        press(16'h0103, 1'b0, 16'h0000);
        check("after_press_status", 32'(status),      32'h0103);
        check("after_press_pulse",  32'(press_pulse), 32'h0);

        // Release bounce shorter than the debounce window.
        stop_n_raw = 1'b1;
        tick(3);
        stop_n_raw = 1'b0;
        tick(6);
        check("release_bounce_status", 32'(status), 32'h0103);

        release_sw(16'h0106);
        check("after_release_status", 32'(status), 32'h0106);

        bus_cycle(16'h0084, 16'h0001, 1'b1);
        check("clear_press_flag", 32'(status), 32'h0104);
        bus_cycle(16'h0084, 16'h7ffc, 1'b1);
        check("ignored_bits", 32'(status), 32'h0104);

        press(16'h0203, 1'b1, 16'h0003);
        check("set_beats_clear", 32'(status), 32'h0203);
        bus_cycle(16'h0086, 16'h0001, 1'b1);
        check("other_addr", 32'(status), 32'h0203);
        bus_cycle(16'h0084, 16'h8003, 1'b0);
        check("no_wen", 32'(status), 32'h0203);
        release_sw(16'h0206);

        // Count runs from 3 to 256, wrapping to 0 on the last press.
        for (int i = 3; i <= 256; i++) begin
            press({8'(i), 8'h07}, 1'b0, 16'h0000);
            release_sw({8'(i), 8'h06});
        end
        check("count_wrap", 32'(status), 32'h0006);

        press(16'h0107, 1'b1, 16'h8000);
        release_sw(16'h0106);
        bus_cycle(16'h0084, 16'h8000, 1'b1);
        check("count_clear", 32'(status), 32'h0006);

        // Reset in PRESS_WAIT at cnt=2 with the switch still held.
        stop_n_raw = 1'b0;
        tick(5);
        rst = 1'b1;
        #1;
        check("midwait_reset_status", 32'(status),      32'h0000);
        check("midwait_reset_level",  32'(stop_level),  32'h0);
        check("midwait_reset_pulse",  32'(press_pulse), 32'h0);
        tick(2);
        check("held_reset_status", 32'(status), 32'h0000);
        rst = 1'b0;
        exp_q.push_back('{at: cyc + LAT, st: 16'h0103, pulse: 1'b1, lvl: 1'b1});
        tick(LAT + 3);
        release_sw(16'h0106);

        tick(4);
        check("pending_events", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
